// File: rtl/patrick_motion_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// patrick_pkg
//   Shared definitions for the player-sprite motion controller.
//   - motion_state_t : vertical motion states (GROUND, RISE, FALL, LAND)
//   - *_DEF          : default physics constants (pixels / frame, y grows down)
//   - clamp_fall()   : signed upper clamp used for terminal fall speed
// -----------------------------------------------------------------------------
package patrick_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2,
    LAND   = 2'd3
  } motion_state_t;

  localparam logic [9:0] JUMP_V0_DEF  = 10'd12;
  localparam logic [9:0] GRAVITY_DEF  = 10'd1;
  localparam logic [9:0] MAX_FALL_DEF = 10'd12;
  localparam logic [9:0] GROUND_Y_DEF = 10'd400;

  // Returns v limited to at most 'limit', both read as 10-bit two's complement.
  function automatic logic [9:0] clamp_fall(input logic [9:0] v, input logic [9:0] limit);
    return ($signed(v) > $signed(limit)) ? limit : v;
  endfunction

endpackage

// File: rtl/patrick_motion_ctrl_key_arbiter.sv
// -----------------------------------------------------------------------------
// key_arbiter
//   Turns left/right key levels into one-cycle direction-change pulses.
//   A rising key always wins (right over left when both rise together). When
//   the most recently pressed key is released while the other key is still
//   held, control hands back to the held key with a single pulse.
//
// Ports
//   CLK        in   clock
//   Reset      in   synchronous, active-low reset
//   key_left   in   left key level (synchronous to CLK)
//   key_right  in   right key level (synchronous to CLK)
//   right_en   out  one-cycle pulse: move right
//   left_en    out  one-cycle pulse: move left
// -----------------------------------------------------------------------------
module key_arbiter (
  input  logic CLK,
  input  logic Reset,
  input  logic key_left,
  input  logic key_right,
  output logic right_en,
  output logic left_en
);

  logic left_prev_reg;
  logic right_prev_reg;
  // 1 = right was the last direction granted, 0 = left.
  logic last_right_reg;

  logic right_rise;
  logic left_rise;
  logic right_fall;
  logic left_fall;
  logic right_next;
  logic left_next;

  always_comb begin
    right_rise = key_right & ~right_prev_reg;
    left_rise  = key_left  & ~left_prev_reg;
    right_fall = ~key_right & right_prev_reg;
    left_fall  = ~key_left  & left_prev_reg;

    right_next = 1'b0;
    left_next  = 1'b0;
    // Priority chain guarantees the two pulses are mutually exclusive.
    if (right_rise) begin
      right_next = 1'b1;
    end else if (left_rise) begin
      left_next = 1'b1;
    end else if (last_right_reg && right_fall && key_left) begin
      left_next = 1'b1;
    end else if (!last_right_reg && left_fall && key_right) begin
      right_next = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      left_prev_reg  <= 1'b0;
      right_prev_reg <= 1'b0;
      last_right_reg <= 1'b0;
      right_en       <= 1'b0;
      left_en        <= 1'b0;
    end else begin
      left_prev_reg  <= key_left;
      right_prev_reg <= key_right;
      right_en       <= right_next;
      left_en        <= left_next;
      if (right_next) begin
        last_right_reg <= 1'b1;
      end else if (left_next) begin
        last_right_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/patrick_motion_ctrl.sv
// -----------------------------------------------------------------------------
// patrick_motion_ctrl
//   Motion controller for the player sprite. Horizontal key handling is
//   delegated to key_arbiter; the vertical jump (rise, apex, gravity fall,
//   clamped landing) is sequenced here once per video frame.
//
// Ports
//   CLK          in   clock
//   Reset        in   synchronous, active-low reset
//   frame_tick   in   one-cycle pulse per video frame
//   key_left     in   left key level
//   key_right    in   right key level
//   key_jump     in   jump key level
//   Ball_Y_Pos   in   current sprite y (unsigned, grows downward)
//   right_en     out  one-cycle pulse: move right
//   left_en      out  one-cycle pulse: move left
//   Ball_Y_Move  out  signed y delta for the current frame
//   in_air       out  high whenever the sprite is not on the ground
//   land         out  one-cycle pulse when a landing completes
// -----------------------------------------------------------------------------
module patrick_motion_ctrl
  import patrick_pkg::*;
#(
  parameter logic [9:0] JUMP_V0  = JUMP_V0_DEF,
  parameter logic [9:0] GRAVITY  = GRAVITY_DEF,
  parameter logic [9:0] MAX_FALL = MAX_FALL_DEF,
  parameter logic [9:0] GROUND_Y = GROUND_Y_DEF
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic [9:0] Ball_Y_Pos,
  output logic       right_en,
  output logic       left_en,
  output logic [9:0] Ball_Y_Move,
  output logic       in_air,
  output logic       land
);

  // ---------------------------------------------------------------------------
  // Horizontal arbitration
  // ---------------------------------------------------------------------------
  key_arbiter u_key_arbiter (
    .CLK       (CLK),
    .Reset     (Reset),
    .key_left  (key_left),
    .key_right (key_right),
    .right_en  (right_en),
    .left_en   (left_en)
  );

  // ---------------------------------------------------------------------------
  // Vertical FSM
  // ---------------------------------------------------------------------------
  motion_state_t state_reg;
  logic [9:0]    vy_reg;
  logic          jump_armed_reg;
  logic          in_air_reg;
  logic          land_reg;

  logic [9:0]    vy_inc;
  logic [9:0]    vy_fall;
  logic [10:0]   fall_sum;

  always_comb begin
    vy_inc   = vy_reg + GRAVITY;
    vy_fall  = clamp_fall(vy_inc, MAX_FALL);
    // One extra bit so a near-ground position plus speed cannot wrap past 1023.
    fall_sum = {1'b0, Ball_Y_Pos} + {1'b0, vy_fall};
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_reg      <= GROUND;
      vy_reg         <= '0;
      jump_armed_reg <= 1'b1;
      in_air_reg     <= 1'b0;
      land_reg       <= 1'b0;
    end else begin
      land_reg <= 1'b0;

      // Re-arming on any released cycle means a held key yields exactly one jump.
      if (!key_jump) begin
        jump_armed_reg <= 1'b1;
      end

      if (frame_tick) begin
        case (state_reg)
          GROUND: begin
            vy_reg <= '0;
            if (key_jump && jump_armed_reg) begin
              state_reg      <= RISE;
              vy_reg         <= '0 - JUMP_V0;
              jump_armed_reg <= 1'b0;
              in_air_reg     <= 1'b1;
            end
          end

          RISE: begin
            vy_reg <= vy_inc;
            // Apex reached once the velocity is no longer negative.
            if (!vy_inc[9]) begin
              state_reg <= FALL;
            end
          end

          FALL: begin
            if (fall_sum >= {1'b0, GROUND_Y}) begin
              // Final move lands the sprite exactly on the ground line.
              state_reg <= LAND;
              vy_reg    <= GROUND_Y - Ball_Y_Pos;
            end else begin
              vy_reg <= vy_fall;
            end
          end

          LAND: begin
            state_reg  <= GROUND;
            vy_reg     <= '0;
            land_reg   <= 1'b1;
            in_air_reg <= 1'b0;
          end

          default: begin
            state_reg  <= GROUND;
            vy_reg     <= '0;
            in_air_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Ball_Y_Move = vy_reg;
  assign in_air      = in_air_reg;
  assign land        = land_reg;

endmodule

// File: tb/tb_patrick_motion_ctrl.sv
module tb_patrick_motion_ctrl;

  localparam int V0     = 12;
  localparam int GRAV   = 1;
  localparam int MAXF   = 12;
  localparam int GROUND = 400;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic       key_left;
  logic       key_right;
  logic       key_jump;
  logic [9:0] Ball_Y_Pos;
  logic       right_en;
  logic       left_en;
  logic [9:0] Ball_Y_Move;
  logic       in_air;
  logic       land;

  always #5 CLK = ~CLK;

  patrick_motion_ctrl dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_jump    (key_jump),
    .Ball_Y_Pos  (Ball_Y_Pos),
    .right_en    (right_en),
    .left_en     (left_en),
    .Ball_Y_Move (Ball_Y_Move),
    .in_air      (in_air),
    .land        (land)
  );

  typedef struct {
    bit         tick;
    bit         r;
    bit         l;
    logic [9:0] move;
    bit         air;
    bit         lnd;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state (behavioural, integer arithmetic)
  bit m_pr, m_pl;     // previous key levels
  int m_last;         // 0 none, 1 right, 2 left: most recently pressed
  int m_active;       // direction currently granted: 0 none, 1 right, 2 left
  int m_vy;           // vertical speed, signed
  bit m_air;          // sprite off the ground
  bit m_touch;        // touched down, landing frame pending
  bit m_armed;
  int m_y;            // plant integrator driving Ball_Y_Pos
  bit clamp_req = 0;
  bit rand_perturb = 0;

  // Observations of the DUT for phase-level checks
  int dut_y, dut_min, dut_lands, frame_no;

  function automatic void chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endfunction

  task automatic drive(input bit rst_n, input bit tk, input bit kl, input bit kr, input bit kj);
    exp_t e;
    bit rr, rl, jumped;
    int na, nv;
    @(negedge CLK);
    if (clamp_req && m_air && !m_touch && m_vy == 4) begin
      m_y = 395;
      clamp_req = 0;
    end
    if (rand_perturb && m_air && !m_touch && m_vy >= 0 && ($urandom % 16) == 0)
      m_y = $urandom_range(330, 399);
    Reset = rst_n; frame_tick = tk; key_left = kl; key_right = kr; key_jump = kj;
    Ball_Y_Pos = m_y[9:0];
    e.tick = tk & rst_n;
    e.lnd = 0;
    if (!rst_n) begin
      m_pr = 0; m_pl = 0; m_last = 0; m_active = 0;
      m_vy = 0; m_air = 0; m_touch = 0; m_armed = 1;
      e.r = 0; e.l = 0;
    end else begin
      // Horizontal: grant goes to the last-pressed key if held, else the other held key.
      rr = kr & !m_pr;
      rl = kl & !m_pl;
      if (rr) m_last = 1;
      else if (rl) m_last = 2;
      na = 0;
      if (m_last == 1 && kr) na = 1;
      else if (m_last == 2 && kl) na = 2;
      else if (kr) na = 1;
      else if (kl) na = 2;
      e.r = (na == 1 && m_active != 1);
      e.l = (na == 2 && m_active != 2);
      m_active = na; m_pr = kr; m_pl = kl;
      // Vertical: one physics step per frame.
      jumped = 0;
      if (tk) begin
        if (!m_air) begin
          m_vy = 0;
          if (kj && m_armed) begin m_vy = -V0; m_air = 1; jumped = 1; end
        end else if (m_touch) begin
          m_vy = 0; m_air = 0; m_touch = 0; e.lnd = 1;
        end else if (m_vy < 0) begin
          m_vy = m_vy + GRAV;
        end else begin
          nv = (m_vy + GRAV > MAXF) ? MAXF : m_vy + GRAV;
          if (m_y + nv >= GROUND) begin m_vy = GROUND - m_y; m_touch = 1; end
          else m_vy = nv;
        end
      end
      if (!kj) m_armed = 1;
      else if (jumped) m_armed = 0;
    end
    e.move = m_vy[9:0];
    e.air  = m_air;
    q.push_back(e);
    if (rst_n && tk) m_y = m_y + m_vy;
  endtask

  task automatic frames(input int n, input int gap, input bit kl, input bit kr, input bit kj);
    for (int i = 0; i < n; i++) begin
      drive(1, 1, kl, kr, kj);
      for (int g = 1; g < gap; g++) drive(1, 0, kl, kr, kj);
    end
  endtask

  task automatic idle(input int n, input bit kl, input bit kr, input bit kj);
    for (int i = 0; i < n; i++) drive(1, 0, kl, kr, kj);
  endtask

  task automatic drain();
    repeat (3) @(posedge CLK);
    #2;
  endtask

  task automatic phase_start();
    dut_y = GROUND; dut_min = GROUND; dut_lands = 0;
  endtask

  // Monitor: pops one expected transaction per cycle and compares.
  initial begin : monitor
    exp_t e;
    frame_no = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("right_en", int'(right_en), int'(e.r));
        chk("left_en", int'(left_en), int'(e.l));
        chk("Ball_Y_Move", $signed(Ball_Y_Move), $signed(e.move));
        chk("in_air", int'(in_air), int'(e.air));
        chk("land", int'(land), int'(e.lnd));
        if (land) dut_lands++;
        if (right_en || left_en)
          $display("key pulse: right_en=%0b left_en=%0b", right_en, left_en);
        if (e.tick) begin
          frame_no++;
          dut_y = dut_y + $signed(Ball_Y_Move);
          if (dut_y < dut_min) dut_min = dut_y;
          $display("frame %0d: move=%0d y=%0d in_air=%0b land=%0b",
                   frame_no, $signed(Ball_Y_Move), dut_y, in_air, land);
        end
      end
    end
  end

  initial begin : stimulus
    bit kl, kr, kj, tk, rn;
    Reset = 0; frame_tick = 0; key_left = 0; key_right = 0; key_jump = 0;
    m_y = GROUND; Ball_Y_Pos = 10'd400;
    m_pr = 0; m_pl = 0; m_last = 0; m_active = 0;
    m_vy = 0; m_air = 0; m_touch = 0; m_armed = 1;
    phase_start();

    // Reset held with every input high: reset wins over frame_tick.
    repeat (3) drive(0, 1, 1, 1, 1);
    idle(3, 0, 0, 0);

    // Horizontal edges
    idle(3, 0, 1, 0);          // right rises -> one right pulse
    idle(2, 0, 0, 0);
    idle(3, 1, 1, 0);          // both rise -> right only
    idle(2, 0, 0, 0);
    idle(2, 1, 0, 0);          // L
    idle(2, 1, 1, 0);          // then R
    idle(2, 1, 0, 0);          // release R -> back to L
    idle(2, 0, 0, 0);

    // Full jump from the ground line
    phase_start();
    drive(1, 1, 0, 0, 1);
    frames(30, 3, 0, 0, 0);
    drain();
    chk("apex_y", dut_min, 322);
    chk("landed_y", dut_y, GROUND);
    chk("full_jump_lands", dut_lands, 1);

    // Landing clamp: fall redirected to y=395 while speed is 4
    phase_start();
    clamp_req = 1;
    drive(1, 1, 0, 0, 1);
    frames(30, 2, 0, 0, 0);
    drain();
    chk("clamp_consumed", int'(clamp_req), 0);
    chk("clamp_lands", dut_lands, 1);

    // Held jump key: one jump only, then release/re-press starts a new one
    phase_start();
    drive(1, 1, 0, 0, 1);
    frames(35, 2, 0, 0, 1);
    drain();
    chk("held_jump_lands", dut_lands, 1);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 1);
    frames(30, 2, 0, 0, 0);
    drain();
    chk("repress_lands", dut_lands, 2);

    // Reset mid-jump: back on the ground, no landing pulse
    phase_start();
    drive(1, 1, 0, 0, 1);
    frames(5, 2, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    m_y = GROUND;
    frames(5, 2, 0, 0, 0);
    drain();
    chk("reset_midjump_lands", dut_lands, 0);

    // Randomized traffic
    rand_perturb = 1;
    kl = 0; kr = 0; kj = 0;
    for (int i = 0; i < 1500; i++) begin
      if (($urandom % 8) == 0) kl = ~kl;
      if (($urandom % 8) == 0) kr = ~kr;
      if (($urandom % 8) == 0) kj = ~kj;
      tk = (($urandom % 3) == 0);
      rn = (($urandom % 500) != 0);
      drive(rn, tk, kl, kr, kj);
    end
    drain();
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
